pts_wrapper: RTL and testbench

Parallel-to-serial unloader for the FFT datapath: the transmit-side counterpart of the serial-to-parallel input wrapper. It captures a full frame of NUM_WORDS parallel words (default 48 × 16 bit) in one cycle, then presents them one word per strobe on a 16-bit serial output, word 0 first. Typical use: draining FFT result frames to a downstream word-serial consumer that paces transfers with a strobe.

---
 rtl/pts_wrapper.sv | 145 ++++++++++++++
 tb/tb_pts_wrapper.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pts_wrapper.sv
// pts_wrapper: parallel-to-serial frame unloader.
// Captures NUM_WORDS words of WORD_W bits in a single cycle and then presents
// them one word per shift_strobe on serial_out, word 0 first.
// Optional feature macro: PTS_RELOAD_EN. When it is defined, a load that
// coincides with the final strobe of a frame starts the next frame with no
// idle bubble. When it is undefined, that load is dropped and flagged.
module pts_wrapper #(
    parameter int NUM_WORDS = 48,
    parameter int WORD_W    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic [NUM_WORDS-1:0][WORD_W-1:0]  data_par,
    input  logic                              shift_strobe,
    output logic [WORD_W-1:0]                 serial_out,
    output logic                              out_valid,
    output logic                              busy,
    output logic                              done,
    output logic                              load_drop
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

`ifdef PTS_RELOAD_EN
    localparam bit RELOAD_EN = 1'b1;
`else
    localparam bit RELOAD_EN = 1'b0;
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0]    serial_q, serial_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 drop_q, drop_d;
    logic                 capture;
    logic [IDX_W-1:0]     idx_inc;
    logic [WORD_W-1:0]    buf_word [NUM_WORDS];

    assign idx_inc = idx_q + 1'b1;

    // Frame buffer: every word is captured together when a load is accepted
    // and otherwise holds, so data_par changes never disturb a frame in flight.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_buf
            logic [WORD_W-1:0] word_q;

            // Capture word gi of the incoming frame on an accepted load.
            always_ff @(posedge clk) begin
                if (capture) begin
                    word_q <= data_par[gi];
                end
            end

            assign buf_word[gi] = word_q;
        end
    endgenerate

    // Next-state, next-word and flag computation for the IDLE/SHIFT machine.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        serial_d = serial_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        drop_d   = 1'b0;
        capture  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Strobes in IDLE are ignored entirely.
                if (load) begin
                    capture  = 1'b1;
                    idx_d    = '0;
                    serial_d = data_par[0];
                    valid_d  = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (shift_strobe && (idx_q == LAST_IDX)) begin
                    // Last word consumed: the frame is complete.
                    done_d = 1'b1;
                    if (load && RELOAD_EN) begin
                        capture  = 1'b1;
                        idx_d    = '0;
                        serial_d = data_par[0];
                        valid_d  = 1'b1;
                    end else begin
                        state_d  = S_IDLE;
                        idx_d    = '0;
                        serial_d = '0;
                        valid_d  = 1'b0;
                        drop_d   = load;
                    end
                end else begin
                    // A load mid-frame is refused; the buffer is untouched.
                    drop_d = load;
                    if (shift_strobe) begin
                        idx_d    = idx_inc;
                        serial_d = buf_word[idx_inc];
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                idx_d    = '0;
                serial_d = '0;
                valid_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset overrides load and strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            serial_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    assign serial_out = serial_q;
    assign out_valid  = valid_q;
    assign busy       = valid_q;
    assign done       = done_q;
    assign load_drop  = drop_q;

endmodule

// File: tb/tb_pts_wrapper.sv
// tb_pts_wrapper: directed self-checking bench for pts_wrapper.
// Follows the build's PTS_RELOAD_EN setting for the final-cycle load case.
module tb_pts_wrapper;

    localparam int NUM_WORDS = 48;
    localparam int WORD_W    = 16;

    logic                             clk;
    logic                             rst;
    logic                             load;
    logic [NUM_WORDS-1:0][WORD_W-1:0] data_par;
    logic                             shift_strobe;
    logic [WORD_W-1:0]                serial_out;
    logic                             out_valid;
    logic                             busy;
    logic                             done;
    logic                             load_drop;

    int n_cmp = 0;
    int n_err = 0;

    pts_wrapper #(
        .NUM_WORDS (NUM_WORDS),
        .WORD_W    (WORD_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .data_par     (data_par),
        .shift_strobe (shift_strobe),
        .serial_out   (serial_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done),
        .load_drop    (load_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input int base);
        for (int i = 0; i < NUM_WORDS; i++) data_par[i] = WORD_W'(base + i);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".busy"},  {31'd0, busy},      32'd0);
        chk({tag, ".data"},  {16'd0, serial_out}, 32'd0);
        chk({tag, ".done"},  {31'd0, done},      32'd0);
        chk({tag, ".drop"},  {31'd0, load_drop}, 32'd0);
    endtask

    task automatic chk_word(input string tag, input int exp);
        chk({tag, ".data"},  {16'd0, serial_out}, 32'(exp));
        chk({tag, ".valid"}, {31'd0, out_valid},  32'd1);
        chk({tag, ".busy"},  {31'd0, busy},       32'd1);
        chk({tag, ".done"},  {31'd0, done},       32'd0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; shift_strobe = 1'b0;
        set_frame(0);

        // Reset state
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        $display("txn reset: outputs checked");

        // Idle noise: strobes while IDLE do nothing
        for (int i = 0; i < 6; i++) begin
            shift_strobe = (i % 2 == 0);
            tick();
            chk_idle("idle_noise");
        end
        shift_strobe = 1'b0;
        $display("txn idle noise: 6 cycles checked");

        // Basic frame with held strobe; data_par is scrambled after the load
        set_frame(0);
        load = 1'b1;
        tick();
        load = 1'b0;
        set_frame(16'hDE00);
        shift_strobe = 1'b1;
        for (int i = 0; i < NUM_WORDS; i++) begin
            chk_word("basic", i);
            tick();
        end
        shift_strobe = 1'b0;
        chk("basic.done",  {31'd0, done},      32'd1);
        chk("basic.valid", {31'd0, out_valid}, 32'd0);
        chk("basic.data",  {16'd0, serial_out}, 32'd0);
        tick();
        chk_idle("basic.after");
        $display("txn basic frame: 48 words held strobe");

        // Gapped strobes: one strobe every third cycle
        set_frame(0);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            for (int g = 0; g < 3; g++) begin
                chk_word("gapped", w);
                shift_strobe = (g == 2);
                tick();
            end
            shift_strobe = 1'b0;
        end
        chk("gapped.done",  {31'd0, done},      32'd1);
        chk("gapped.valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk_idle("gapped.after");
        $display("txn gapped frame: 48 words, strobe every 3rd cycle");

        // Load while busy is dropped, frame continues unchanged
        set_frame(16'hA000);
        load = 1'b1;
        tick();
        load = 1'b0;
        shift_strobe = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk_word("busy_load", 16'hA000 + i);
            tick();
        end
        shift_strobe = 1'b0;
        set_frame(16'hFFFF);
        for (int i = 0; i < NUM_WORDS; i++) data_par[i] = 16'hFFFF;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("busy_load.drop", {31'd0, load_drop}, 32'd1);
        chk_word("busy_load.hold", 16'hA00A);
        tick();
        chk("busy_load.drop_end", {31'd0, load_drop}, 32'd0);
        shift_strobe = 1'b1;
        for (int i = 10; i < NUM_WORDS; i++) begin
            chk_word("busy_load.rest", 16'hA000 + i);
            tick();
        end
        shift_strobe = 1'b0;
        chk("busy_load.done", {31'd0, done}, 32'd1);
        tick();
        chk_idle("busy_load.after");
        $display("txn load while busy: drop flagged, frame intact");

        // Reset mid-frame after 20 words
        set_frame(16'h5000);
        load = 1'b1;
        tick();
        load = 1'b0;
        shift_strobe = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk_word("midrst", 16'h5000 + i);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("midrst.reset");
        tick();
        chk_idle("midrst.reset2");
        shift_strobe = 1'b0;
        set_frame(16'h6000);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk_word("midrst.restart", 16'h6000);
        $display("txn reset mid-frame: no done, restart at word 0");

        // Final-cycle load, continuing the restarted frame
        shift_strobe = 1'b1;
        for (int i = 0; i < NUM_WORDS - 1; i++) begin
            chk_word("final", 16'h6000 + i);
            tick();
        end
        chk_word("final.last", 16'h602F);
        set_frame(16'h7000);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("final.done", {31'd0, done}, 32'd1);
`ifdef PTS_RELOAD_EN
        chk("final.valid", {31'd0, out_valid},  32'd1);
        chk("final.data",  {16'd0, serial_out}, 32'h7000);
        chk("final.drop",  {31'd0, load_drop},  32'd0);
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (i != 0) chk_word("reload", 16'h7000 + i);
            else chk("reload.data0", {16'd0, serial_out}, 32'h7000);
            tick();
        end
        shift_strobe = 1'b0;
        chk("reload.done", {31'd0, done}, 32'd1);
        chk("reload.valid", {31'd0, out_valid}, 32'd0);
        $display("txn final-cycle load: reloaded without bubble");
`else
        shift_strobe = 1'b0;
        chk("final.valid", {31'd0, out_valid},  32'd0);
        chk("final.data",  {16'd0, serial_out}, 32'd0);
        chk("final.drop",  {31'd0, load_drop},  32'd1);
        $display("txn final-cycle load: dropped, back to idle");
`endif
        tick();
        chk_idle("final.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
